// File: rtl/data_memory.sv
// Byte-lane data memory with a posted store queue that forwards the youngest matching store to loads.
// Optional DMEM_ALIGN_CHECK_EN drops misaligned stores and raises a sticky misaligned flag.
module data_memory #(
  parameter int MEM_WORDS = 2048,
  parameter int QDEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_data_in [0:3],
  input  logic        mem_write_en,
  input  logic        halted,
  output logic [7:0]  mem_data_out [0:3],
  output logic        full,
  output logic        drained
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        misaligned
`endif
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int QW = $clog2(QDEPTH);

  typedef logic [AW-1:0] idx_t;

  logic [31:0]   mem_q   [MEM_WORDS];
  idx_t          q_idx_q [QDEPTH];
  logic [31:0]   q_dat_q [QDEPTH];
  logic [QW-1:0] head_q, head_d;
  logic [QW-1:0] tail_q, tail_d;
  logic [QW:0]   count_q, count_d;

  idx_t          addr_idx;
  logic [31:0]   wr_word;
  logic [31:0]   rd_word;
  logic [QW-1:0] slot;
  logic          empty;
  logic          store_ok;
  logic          enq;
  logic          drain;
  logic          unused_addr;

  assign addr_idx    = mem_addr[AW+1:2];
  assign unused_addr = ^{mem_addr[31:AW+2], mem_addr[1:0]};
  assign wr_word     = {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]};
  assign empty       = (count_q == '0);
  assign full        = (count_q == (QW+1)'(QDEPTH));
  assign drained     = halted && empty;

`ifdef DMEM_ALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;
  logic aligned;

  assign aligned      = (mem_addr[1:0] == 2'b00);
  assign store_ok     = mem_write_en && !halted && aligned;
  assign misaligned_d = misaligned_q || (mem_write_en && !halted && !aligned);
  assign misaligned   = misaligned_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) misaligned_q <= 1'b0;
    else        misaligned_q <= misaligned_d;
  end
`else
  assign store_ok = mem_write_en && !halted;
`endif

  // A store into a full queue forces the oldest entry out on the same edge.
  assign enq   = store_ok;
  assign drain = !empty && (!store_ok || full);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) head_d = head_q + QW'(1);
    if (enq)   tail_d = tail_q + QW'(1);
    if (enq && !drain)      count_d = count_q + (QW+1)'(1);
    else if (!enq && drain) count_d = count_q - (QW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue payload and the backing array are not reset; an edge under reset never writes the array.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_idx_q[tail_q] <= addr_idx;
      q_dat_q[tail_q] <= wr_word;
    end
    if (drain && rst_b) mem_q[q_idx_q[head_q]] <= q_dat_q[head_q];
  end

  // Walk oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    rd_word = mem_q[addr_idx];
    slot    = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      slot = head_q + QW'(i);
      if (((QW+1)'(i) < count_q) && (q_idx_q[slot] == addr_idx)) rd_word = q_dat_q[slot];
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) mem_data_out[k] = rd_word[8*k +: 8];
  end

endmodule
